// File: rtl/uart_pkg.sv
// Shared types and the parity formula for the UART parity block.
// Used by both the TX parity path and the RX parity checker.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_EVEN  = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_MARK  = 2'b10,
        PAR_SPACE = 2'b11
    } par_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        PAR  = 2'b10
    } rx_par_state_e;

    function automatic logic par_calc(par_mode_e mode, logic xor_bit);
        logic p;
        p = 1'b0;
        unique case (mode)
            PAR_EVEN:  p = xor_bit;
            PAR_ODD:   p = ~xor_bit;
            PAR_MARK:  p = 1'b1;
            PAR_SPACE: p = 1'b0;
            default:   p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_par_rx_chk.sv
// RX parity checker: frame FSM, running XOR of data bits, bit counter
// and the saturating parity-error counter.
module uart_par_rx_chk
    import uart_pkg::*;
#(
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Par_En,
    input  par_mode_e        Par_Mode,
    input  logic [LEN_W-1:0] Rx_Len,
    input  logic             Rx_Start,
    input  logic             Rx_Bit,
    input  logic             Rx_Bit_Valid,
    input  logic             Rx_Par_Bit,
    input  logic             Rx_Par_Valid,
    input  logic             Err_Cnt_Clr,
    output logic             Par_Err,
    output logic [CNT_W-1:0] Par_Err_Cnt
);

    rx_par_state_e    state_q, state_d;
    logic             acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    par_mode_e        mode_q, mode_d;
    logic             err_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            acc_q       <= 1'b0;
            cnt_q       <= '0;
            len_q       <= '0;
            mode_q      <= PAR_EVEN;
            Par_Err     <= 1'b0;
            Par_Err_Cnt <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            Par_Err <= err_d;
            // Clear wins over a same-cycle increment
            if (Err_Cnt_Clr) begin
                Par_Err_Cnt <= '0;
            end else if (Par_Err && (Par_Err_Cnt != '1)) begin
                Par_Err_Cnt <= Par_Err_Cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        mode_d  = mode_q;
        err_d   = 1'b0;
        if (Par_En && Rx_Start) begin
            state_d = DATA;
            acc_d   = 1'b0;
            cnt_d   = '0;
            len_d   = Rx_Len;
            mode_d  = Par_Mode;
        end else if (!Par_En) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                end
                DATA: begin
                    if (Rx_Bit_Valid) begin
                        acc_d = acc_q ^ Rx_Bit;
                        cnt_d = cnt_q + LEN_W'(1);
                        if (cnt_d == len_q) begin
                            state_d = PAR;
                        end
                    end
                end
                PAR: begin
                    if (Rx_Par_Valid) begin
                        err_d   = Rx_Par_Bit != par_calc(mode_q, acc_q);
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_parity_unit.sv
// UART parity unit: registered TX parity generation plus the RX
// parity checker with its saturating error counter.
module uart_parity_unit
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = $clog2(WIDTH + 1),
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Par_En,
    input  logic [1:0]       Par_Mode,
    input  logic [LEN_W-1:0] Data_Len,
    input  logic [WIDTH-1:0] P_DATA,
    input  logic             Data_Valid,
    output logic             Parity,
    output logic             Parity_Valid,
    input  logic             Rx_Start,
    input  logic             Rx_Bit,
    input  logic             Rx_Bit_Valid,
    input  logic             Rx_Par_Bit,
    input  logic             Rx_Par_Valid,
    output logic             Par_Err,
    output logic [CNT_W-1:0] Par_Err_Cnt,
    input  logic             Err_Cnt_Clr
);

    logic [LEN_W-1:0] eff_len;
    logic [WIDTH-1:0] data_mask;
    logic [WIDTH-1:0] data_q;
    par_mode_e        mode_q;
    logic             ld_q;
    logic             load;

    // Out-of-range lengths fall back to the full word
    always_comb begin
        eff_len = Data_Len;
        if ((Data_Len == '0) || (int'(Data_Len) > WIDTH)) begin
            eff_len = LEN_W'(WIDTH);
        end
        for (int i = 0; i < WIDTH; i++) begin
            data_mask[i] = P_DATA[i] & (i < int'(eff_len));
        end
    end

    assign load = Data_Valid && Par_En;

    always_ff @(posedge CLK) begin
        if (RST) begin
            data_q       <= '0;
            mode_q       <= PAR_EVEN;
            ld_q         <= 1'b0;
            Parity       <= 1'b0;
            Parity_Valid <= 1'b0;
        end else begin
            ld_q         <= load;
            Parity_Valid <= ld_q;
            if (load) begin
                data_q <= data_mask;
                mode_q <= par_mode_e'(Par_Mode);
            end
            if (ld_q) begin
                Parity <= par_calc(mode_q, ^data_q);
            end
        end
    end

    uart_par_rx_chk #(
        .LEN_W(LEN_W),
        .CNT_W(CNT_W)
    ) u_rx_chk (
        .CLK         (CLK),
        .RST         (RST),
        .Par_En      (Par_En),
        .Par_Mode    (par_mode_e'(Par_Mode)),
        .Rx_Len      (eff_len),
        .Rx_Start    (Rx_Start),
        .Rx_Bit      (Rx_Bit),
        .Rx_Bit_Valid(Rx_Bit_Valid),
        .Rx_Par_Bit  (Rx_Par_Bit),
        .Rx_Par_Valid(Rx_Par_Valid),
        .Err_Cnt_Clr (Err_Cnt_Clr),
        .Par_Err     (Par_Err),
        .Par_Err_Cnt (Par_Err_Cnt)
    );

endmodule

// File: tb/tb_uart_parity_unit.sv
// Randomised scoreboard bench for uart_parity_unit (CNT_W=8 and CNT_W=2
// instances share stimulus; a reference model predicts every response).
module tb_uart_parity_unit;

    localparam int WIDTH = 8;
    localparam int LEN_W = 4;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             Par_En = 1'b0;
    logic [1:0]       Par_Mode = 2'd0;
    logic [LEN_W-1:0] Data_Len = '0;
    logic [WIDTH-1:0] P_DATA = '0;
    logic             Data_Valid = 1'b0;
    logic             Rx_Start = 1'b0;
    logic             Rx_Bit = 1'b0;
    logic             Rx_Bit_Valid = 1'b0;
    logic             Rx_Par_Bit = 1'b0;
    logic             Rx_Par_Valid = 1'b0;
    logic             Err_Cnt_Clr = 1'b0;

    logic             Parity, Parity_Valid, Par_Err;
    logic [7:0]       Par_Err_Cnt;
    logic             Parity2, Parity_Valid2, Par_Err2;
    logic [1:0]       Par_Err_Cnt2;

    uart_parity_unit #(.WIDTH(WIDTH), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST), .Par_En(Par_En), .Par_Mode(Par_Mode),
        .Data_Len(Data_Len), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
        .Parity(Parity), .Parity_Valid(Parity_Valid),
        .Rx_Start(Rx_Start), .Rx_Bit(Rx_Bit), .Rx_Bit_Valid(Rx_Bit_Valid),
        .Rx_Par_Bit(Rx_Par_Bit), .Rx_Par_Valid(Rx_Par_Valid),
        .Par_Err(Par_Err), .Par_Err_Cnt(Par_Err_Cnt),
        .Err_Cnt_Clr(Err_Cnt_Clr)
    );

    uart_parity_unit #(.WIDTH(WIDTH), .CNT_W(2)) dut2 (
        .CLK(CLK), .RST(RST), .Par_En(Par_En), .Par_Mode(Par_Mode),
        .Data_Len(Data_Len), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
        .Parity(Parity2), .Parity_Valid(Parity_Valid2),
        .Rx_Start(Rx_Start), .Rx_Bit(Rx_Bit), .Rx_Bit_Valid(Rx_Bit_Valid),
        .Rx_Par_Bit(Rx_Par_Bit), .Rx_Par_Valid(Rx_Par_Valid),
        .Par_Err(Par_Err2), .Par_Err_Cnt(Par_Err_Cnt2),
        .Err_Cnt_Clr(Err_Cnt_Clr)
    );

    always #5 CLK = ~CLK;

    int ecnt = 0;
    always @(posedge CLK) ecnt <= ecnt + 1;

    typedef struct {
        int   due;
        logic par;
    } tx_exp_t;

    typedef struct {
        int   due;
        logic err;
        int   c8;
        int   c2;
    } rx_exp_t;

    tx_exp_t tx_q[$];
    rx_exp_t rx_q[$];

    int   checks = 0;
    int   errors = 0;
    int   mc8 = 0;
    int   mc2 = 0;
    int   cnt_due = -1;
    int   cnt_e8 = 0;
    int   cnt_e2 = 0;
    logic last_par = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)",
                     name, act, exp, ecnt);
        end
    endtask

    // Reference model: parity from the count of ones
    function automatic int eff(input int len);
        return (len == 0 || len > WIDTH) ? WIDTH : len;
    endfunction

    function automatic logic ref_par(input int mode, input int ones);
        case (mode)
            0: return (ones % 2) == 1;
            1: return (ones % 2) == 0;
            2: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        Par_En = 1'b0;
        Data_Valid = 1'b0;
        Rx_Start = 1'b0;
        Rx_Bit_Valid = 1'b0;
        Rx_Par_Valid = 1'b0;
        Err_Cnt_Clr = 1'b0;
        tick();
        RST = 1'b0;
        tx_q.delete();
        rx_q.delete();
        cnt_due = -1;
        mc8 = 0;
        mc2 = 0;
        last_par = 1'b0;
        check("rst_parity", Parity, 0);
        check("rst_parity_valid", Parity_Valid, 0);
        check("rst_par_err", Par_Err, 0);
        check("rst_cnt8", Par_Err_Cnt, 0);
        check("rst_cnt2", Par_Err_Cnt2, 0);
    endtask

    task automatic tx_load(input logic [WIDTH-1:0] d, input int mode,
                           input int len, input logic en);
        tx_exp_t e;
        int ones;
        P_DATA = d;
        Par_Mode = 2'(mode);
        Data_Len = LEN_W'(len);
        Par_En = en;
        Data_Valid = 1'b1;
        if (en) begin
            ones = 0;
            for (int i = 0; i < eff(len); i++) ones += d[i];
            e.due = ecnt + 2;
            e.par = ref_par(mode, ones);
            last_par = e.par;
            tx_q.push_back(e);
        end
        tick();
        Data_Valid = 1'b0;
    endtask

    task automatic rx_start(input int mode, input int len);
        Par_En = 1'b1;
        Par_Mode = 2'(mode);
        Data_Len = LEN_W'(len);
        Rx_Start = 1'b1;
        tick();
        Rx_Start = 1'b0;
        Par_Mode = 2'($urandom_range(0, 3));
        Data_Len = LEN_W'($urandom_range(0, 15));
    endtask

    task automatic rx_bit(input logic b);
        Rx_Bit = b;
        Rx_Bit_Valid = 1'b1;
        tick();
        Rx_Bit_Valid = 1'b0;
    endtask

    task automatic rx_frame(input logic [WIDTH-1:0] d, input int mode,
                            input int len, input logic pbit,
                            input bit clr, input bit noise);
        rx_exp_t x;
        int ones;
        int l;
        rx_start(mode, len);
        l = eff(len);
        ones = 0;
        for (int i = 0; i < l; i++) begin
            if (noise && $urandom_range(0, 3) == 0) begin
                Rx_Par_Bit = 1'($urandom);
                Rx_Par_Valid = 1'b1;
                tick();
                Rx_Par_Valid = 1'b0;
            end
            rx_bit(d[i]);
            ones += d[i];
        end
        if (noise && $urandom_range(0, 2) == 0) begin
            rx_bit(1'($urandom));
        end
        x.err = pbit != ref_par(mode, ones);
        if (clr) begin
            mc8 = 0;
            mc2 = 0;
        end else if (x.err) begin
            mc8 = (mc8 < 255) ? mc8 + 1 : 255;
            mc2 = (mc2 < 3) ? mc2 + 1 : 3;
        end
        x.due = ecnt + 1;
        x.c8 = mc8;
        x.c2 = mc2;
        rx_q.push_back(x);
        Rx_Par_Bit = pbit;
        Rx_Par_Valid = 1'b1;
        tick();
        Rx_Par_Valid = 1'b0;
        if (clr) begin
            Err_Cnt_Clr = 1'b1;
            tick();
            Err_Cnt_Clr = 1'b0;
        end
    endtask

    // Monitor: pops expectations when each response is due
    initial begin
        forever begin
            @(posedge CLK);
            #2;
            if (tx_q.size() > 0 && tx_q[0].due == ecnt) begin
                check("tx_valid", Parity_Valid, 1);
                check("tx_parity", Parity, tx_q[0].par);
                check("tx_parity_w2", Parity2, tx_q[0].par);
                void'(tx_q.pop_front());
            end else begin
                check("tx_spurious_valid", Parity_Valid, 0);
                check("tx_spurious_valid_w2", Parity_Valid2, 0);
            end
            if (rx_q.size() > 0 && rx_q[0].due == ecnt) begin
                check("rx_par_err", Par_Err, rx_q[0].err);
                check("rx_par_err_w2", Par_Err2, rx_q[0].err);
                cnt_due = ecnt + 1;
                cnt_e8 = rx_q[0].c8;
                cnt_e2 = rx_q[0].c2;
                void'(rx_q.pop_front());
            end else begin
                check("rx_spurious_err", Par_Err, 0);
            end
            if (cnt_due == ecnt) begin
                check("rx_err_cnt8", Par_Err_Cnt, cnt_e8);
                check("rx_err_cnt2", Par_Err_Cnt2, cnt_e2);
                cnt_due = -1;
            end
        end
    end

    initial begin
        tick();
        do_reset();

        // TX directed
        tx_load(8'hB4, 0, 8, 1'b1);
        tx_load(8'hB4, 1, 8, 1'b1);
        tx_load(8'hE1, 0, 5, 1'b1);
        tx_load(8'hE1, 2, 5, 1'b1);
        tx_load(8'hE1, 3, 5, 1'b1);
        tx_load(8'hFF, 0, 0, 1'b1);
        tx_load(8'hFE, 1, 12, 1'b1);
        repeat (3) tick();

        // TX random, back-to-back with gaps and disabled loads
        for (int n = 0; n < 60; n++) begin
            tx_load(WIDTH'($urandom), $urandom_range(0, 3),
                    $urandom_range(0, 15), $urandom_range(0, 4) != 0);
            if ($urandom_range(0, 2) == 0) tick();
        end
        repeat (3) tick();
        tx_load(~P_DATA, 0, 8, 1'b0);
        repeat (3) tick();
        check("tx_hold_par_en0", Parity, last_par);

        // RX directed
        rx_frame(8'h53, 0, 8, 1'b0, 1'b0, 1'b0);
        rx_frame(8'h53, 0, 8, 1'b1, 1'b0, 1'b0);
        tick();
        check("rx_cnt_after_first_err", Par_Err_Cnt, 1);

        // Restart after 3 bits, then a clean frame
        rx_start(1, 8);
        rx_bit(1'b1);
        rx_bit(1'b0);
        rx_bit(1'b1);
        rx_frame(8'h0F, 1, 8, 1'b1, 1'b0, 1'b1);

        // Par_En drop mid-frame forces idle; later parity is ignored
        rx_start(0, 4);
        rx_bit(1'b1);
        Par_En = 1'b0;
        tick();
        Par_En = 1'b1;
        Rx_Par_Bit = 1'b1;
        Rx_Par_Valid = 1'b1;
        tick();
        Rx_Par_Valid = 1'b0;

        // Saturation of the 2-bit counter
        for (int n = 0; n < 5; n++) begin
            rx_frame(8'h01, 0, 3, 1'b0, 1'b0, 1'b0);
        end
        tick();
        check("rx_cnt2_saturated", Par_Err_Cnt2, 3);
        rx_frame(8'h01, 0, 3, 1'b0, 1'b1, 1'b0);
        tick();

        // RX random frames with noise and mid-frame config changes
        for (int n = 0; n < 80; n++) begin
            rx_frame(WIDTH'($urandom), $urandom_range(0, 3),
                     $urandom_range(0, 15), 1'($urandom),
                     $urandom_range(0, 15) == 0, 1'b1);
            if ($urandom_range(0, 1) == 0) tick();
        end
        repeat (3) tick();

        // Reset while waiting for parity: frame aborts silently
        rx_frame(8'hFF, 0, 2, 1'b1, 1'b0, 1'b0);
        rx_start(0, 4);
        for (int i = 0; i < 4; i++) rx_bit(1'b1);
        do_reset();
        Par_En = 1'b1;
        Rx_Par_Bit = 1'b1;
        Rx_Par_Valid = 1'b1;
        tick();
        Rx_Par_Valid = 1'b0;
        repeat (3) tick();
        check("post_rst_cnt8", Par_Err_Cnt, 0);
        check("post_rst_par_err", Par_Err, 0);

        repeat (4) tick();
        check("tx_queue_drained", tx_q.size(), 0);
        check("rx_queue_drained", rx_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_parity_unit.md
Name: uart_parity_unit

Overview:
- Parametrised UART parity block for the next-generation UART.
- TX side: latches a parallel word and produces a registered parity bit for the serializer. Supports runtime data length and four parity modes (even, odd, mark, space).
- RX side: accumulates parity over serially received data bits, checks the received parity bit, and raises an error pulse.
- Also keeps a saturating error counter, read by the UART status register.

Parameters:
- WIDTH, 8, maximum data-word width in bits (≥2).
- LEN_W, $clog2(WIDTH+1), width of Data_Len.
- CNT_W, 8, width of the parity-error counter.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- Par_En  in  1  parity enable, shared TX/RX.
- Par_Mode  in  2  parity mode: 00 even, 01 odd, 10 mark, 11 space.
- Data_Len  in  LEN_W  active data bits per frame.
- P_DATA  in  WIDTH  TX parallel data, LSB = first bit on line.
- Data_Valid  in  1  TX load strobe.
- Parity  out  1  TX parity bit, registered.
- Parity_Valid  out  1  one-cycle pulse: Parity updated.
- Rx_Start  in  1  RX frame start (start bit accepted).
- Rx_Bit  in  1  sampled RX data bit.
- Rx_Bit_Valid  in  1  Rx_Bit qualifier.
- Rx_Par_Bit  in  1  sampled RX parity bit.
- Rx_Par_Valid  in  1  Rx_Par_Bit qualifier.
- Par_Err  out  1  one-cycle pulse: RX parity mismatch.
- Par_Err_Cnt  out  CNT_W  saturating mismatch count.
- Err_Cnt_Clr  in  1  synchronous clear of Par_Err_Cnt.

Behaviour:
- Reset: on RST=1 at a CLK edge, the following are all 0: Parity, Parity_Valid, Par_Err, Par_Err_Cnt, the RX accumulator and the bit counter. RX FSM goes to IDLE. RST overrides every other input. A reset mid-frame aborts the frame with no error.
- Data length decode: Data_Len 0 or >WIDTH is treated as WIDTH. The effective length L masks P_DATA bits [WIDTH-1:L] to 0 before the XOR.
- TX path:
  - Data_Valid=1 with Par_En=1 latches the masked data, L and Par_Mode.
  - The next edge updates Parity and pulses Parity_Valid, so latency is 2 edges from the Data_Valid edge.
  - Parity per mode: even = ^data; odd = ~^data; mark = 1; space = 0.
  - Par_En=0: Data_Valid is ignored and Parity holds its value.
  - Back-to-back Data_Valid: each load produces its own result in order. Depth-1 pipeline, no stall.
- RX FSM states: IDLE, DATA, PAR.
  - IDLE: Rx_Start with Par_En=1 → DATA. Accumulator and bit count are cleared; L and Par_Mode are captured.
  - DATA: each Rx_Bit_Valid XORs Rx_Bit into the accumulator and increments the count. When the count reaches L → PAR.
  - PAR: on Rx_Par_Valid, compute expected = the TX formula applied to the accumulator. If Rx_Par_Bit ≠ expected, Par_Err pulses for 1 cycle. Either way → IDLE.
- Simultaneous/ignored events:
  - Rx_Par_Valid outside PAR is ignored.
  - Rx_Bit_Valid in IDLE or PAR is ignored.
  - Rx_Start in DATA or PAR restarts the frame and does not flag an error.
- Config changes: changing Par_En, Par_Mode or Data_Len mid-frame has no effect on the current RX frame. Exception: Par_En=0 in DATA or PAR forces IDLE.
- Error counter:
  - Increments on each Par_Err and saturates at 2^CNT_W-1.
  - Err_Cnt_Clr has priority over an increment in the same cycle; the result is 0.
- No combinational input-to-output paths.

Decomposition:
- Package uart_pkg holds:
  - par_mode_e enum: PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE.
  - rx_par_state_e enum: IDLE, DATA, PAR.
  - Function par_calc(mode, xor_bit), shared by TX and RX.
- One sub-module, uart_par_rx_chk, holds the RX FSM, the accumulator and the counter. The top keeps the TX path.

Test Plan:
1. TX even, WIDTH=8, Data_Len=8, P_DATA=0xB4, Data_Valid pulse → Parity=0 and Parity_Valid pulse 2 edges later. Odd mode, same data → Parity=1.
2. TX Data_Len=5, even, P_DATA=0xE1 (masked 0x01) → Parity=1. Mark → 1, space → 0 regardless of data.
3. RX Data_Len=8, even, bits of 0x53 LSB-first, Rx_Par_Bit=0 → no Par_Err. Repeat with Rx_Par_Bit=1 → Par_Err pulse, Par_Err_Cnt=1.
4. RX Rx_Start after 3 data bits, then a full clean frame → no error, counter unchanged. Rx_Par_Valid during DATA is ignored.
5. CNT_W=2: force 5 mismatched frames → Par_Err_Cnt=3 (saturated). Err_Cnt_Clr coincident with a Par_Err → 0.
6. RST=1 for 1 cycle in PAR state → FSM returns to IDLE and all outputs are 0. The following Rx_Par_Valid is ignored.
